// File: rtl/rptr_empty_ctrl.sv
// Read-side pointer and flag control for an asynchronous FIFO.
// Owns the binary/gray read pointer, the memory read address, the empty and
// almost-empty flags, the read-side occupancy count and a sticky underflow flag.
// The gray write pointer arrives already synchronised into clk.
module rptr_empty_ctrl #(
  parameter int unsigned ADDR_LEN      = 5,
  parameter int unsigned AEMPTY_THRESH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd_en,
  input  logic [ADDR_LEN:0]   wptr_sync,
  output logic [ADDR_LEN-1:0] raddr,
  output logic [ADDR_LEN:0]   rptr,
  output logic                empty,
  output logic                almost_empty,
  output logic [ADDR_LEN:0]   rd_count,
  output logic                underflow
);

  localparam int unsigned PTR_W = ADDR_LEN + 1;
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] rbin_next;
  logic [PTR_W-1:0] rgray_next;
  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] count_next;
  logic             rd_fire;

  // Read acceptance and next read pointer in binary and gray form.
  always_comb begin
    rd_fire    = rd_en & ~empty;
    rbin_next  = rbin + PTR_W'(rd_fire);
    rgray_next = (rbin_next >> 1) ^ rbin_next;
  end

  // Gray-to-binary conversion of the synchronised write pointer (XOR prefix from MSB).
  always_comb begin
    wbin = '0;
    for (int i = 0; i < int'(PTR_W); i++) begin
      wbin[i] = ^(wptr_sync >> i);
    end
  end

  // Occupancy after this cycle's read, modulo the pointer range.
  always_comb begin
    count_next = wbin - rbin_next;
  end

  // Memory address is the low bits of the registered binary pointer.
  assign raddr = rbin[ADDR_LEN-1:0];

  // Pointer, count and flag registers; reset dominates.
  always_ff @(posedge clk) begin
    if (rst) begin
      rbin         <= '0;
      rptr         <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
      underflow    <= 1'b0;
    end else begin
      rbin         <= rbin_next;
      rptr         <= rgray_next;
      empty        <= (rgray_next == wptr_sync);
      almost_empty <= (count_next <= AE_TH);
      rd_count     <= count_next;
      underflow    <= underflow | (rd_en & empty);
    end
  end

endmodule

// File: tb/tb_rptr_empty_ctrl.sv
// Scoreboard bench for rptr_empty_ctrl: the driver pushes expected outputs
// computed from an occupancy-level model; the monitor pops and compares.
module tb_rptr_empty_ctrl;

  logic       clk;
  logic       rst;
  logic       rd_en;
  logic [5:0] wptr_sync;
  logic [4:0] raddr;
  logic [5:0] rptr;
  logic       empty;
  logic       almost_empty;
  logic [5:0] rd_count;
  logic       underflow;

  rptr_empty_ctrl #(.ADDR_LEN(5), .AEMPTY_THRESH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_en        (rd_en),
    .wptr_sync    (wptr_sync),
    .raddr        (raddr),
    .rptr         (rptr),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] raddr;
    logic [5:0] rptr;
    logic       empty;
    logic       ae;
    logic [5:0] cnt;
    logic       uf;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Model state: unbounded read/write totals plus the flags seen last cycle.
  int   m_rd    = 0;
  int   wr_idx  = 0;
  bit   m_empty = 1'b1;
  bit   m_uf    = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int gray_of(input int n);
    int b;
    b = n % 64;
    return b ^ (b >> 1);
  endfunction

  function automatic int bin_of_gray(input int g);
    int b;
    b = 0;
    for (int k = 5; k >= 0; k--) begin
      b = b | ((((b >> (k + 1)) & 1) ^ ((g >> k) & 1)) << k);
    end
    return b;
  endfunction

  // Drive one cycle and push the outputs expected after the next posedge.
  task automatic step(input bit rst_v, input bit rd_v);
    exp_t e;
    int   occ;
    bit   fire;
    @(negedge clk);
    rst       = rst_v;
    rd_en     = rd_v;
    wptr_sync = 6'(gray_of(wr_idx));
    e.rst = rst_v;
    if (rst_v) begin
      m_rd    = 0;
      m_empty = 1'b1;
      m_uf    = 1'b0;
      e.raddr = '0; e.rptr = '0; e.empty = 1'b1; e.ae = 1'b1; e.cnt = '0; e.uf = 1'b0;
    end else begin
      fire = rd_v && !m_empty;
      m_uf = m_uf || (rd_v && m_empty);
      m_rd = m_rd + int'(fire);
      occ  = (bin_of_gray(gray_of(wr_idx)) - (m_rd % 64) + 64) % 64;
      m_empty = (occ == 0);
      e.raddr = 5'(m_rd % 32);
      e.rptr  = 6'(gray_of(m_rd));
      e.empty = m_empty;
      e.ae    = (occ <= 4);
      e.cnt   = 6'(occ);
      e.uf    = m_uf;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: sample just after each posedge and compare against the queue head.
  logic [5:0] prev_rptr = '0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("raddr",        int'(raddr),        int'(e.raddr));
      check("rptr",         int'(rptr),         int'(e.rptr));
      check("empty",        int'(empty),        int'(e.empty));
      check("almost_empty", int'(almost_empty), int'(e.ae));
      check("rd_count",     int'(rd_count),     int'(e.cnt));
      check("underflow",    int'(underflow),    int'(e.uf));
      check("rd_count_le_depth", int'(rd_count > 6'd32), 0);
      if (!e.rst) check("rptr_one_bit_step", int'($countones(rptr ^ prev_rptr) > 1), 0);
      prev_rptr = rptr;
    end
  end

  initial begin
    int to;
    rst = 1'b1; rd_en = 1'b0; wptr_sync = '0;

    // Reset for two clocks with the write pointer at zero.
    wr_idx = 0;
    step(1, 0); step(1, 0);

    // Fill view: three words written, no reads.
    wr_idx = 3;
    step(0, 0);

    // Drain three words, then one read while empty sets underflow.
    repeat (4) step(0, 1);

    // Wrap: writer keeps advancing, reader reads continuously past the MSB toggle.
    step(1, 0);
    for (int i = 0; i < 80; i++) begin
      wr_idx = wr_idx + 1;
      step(0, 1);
    end
    repeat (3) step(0, 1);

    // Full occupancy from a freshly reset read pointer.
    wr_idx = 0;
    step(1, 0);
    wr_idx = 32;
    step(0, 0);
    step(0, 0);

    // Reset mid-operation with count 10 and underflow set.
    wr_idx = 0;
    step(1, 0);
    step(0, 1);
    wr_idx = 10;
    step(0, 0);
    step(1, 1);
    step(0, 0);

    // Randomized traffic with legal writer advances and occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        wr_idx = 0;
        step(1, $urandom_range(0, 1) == 1);
      end else begin
        wr_idx = wr_idx + int'($urandom_range(0, 3));
        if (wr_idx - m_rd > 32) wr_idx = m_rd + 32;
        step(0, $urandom_range(0, 2) != 0);
      end
    end

    to = 0;
    while (exp_q.size() != 0 && to < 10) begin
      @(posedge clk);
      to++;
    end
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
